// File: rtl/dm_access_ctrl_if.sv
// Data-memory port bundle between the access controller (master) and a
// variable-latency memory (slave).
interface dm_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Load/store access controller: byte-lane steering, load extension, alignment
// and bus-timeout detection in front of a variable-latency data memory.
module dm_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              busy,
    output logic              exc_align,
    output logic              exc_bus,
    dm_access_ctrl_if.master  mem
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        ERR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size_l;
    logic [1:0]       lane_l;
    logic             sext_l;

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lo[0];
            2'b10:   misaligned = (lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   lane_be = 4'b0001 << lane;
            2'b01:   lane_be = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   lane_wdata = {4{wd[7:0]}};
            2'b01:   lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend by signedness.
    function automatic logic [31:0] load_fmt(input logic [1:0] sz, input logic [1:0] lane,
                                             input logic sext, input logic [31:0] d);
        logic        [31:0] sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] bx;
        logic signed [31:0] hx;
        sh = d >> {lane, 3'b000};
        b  = signed'(sh[7:0]);
        h  = signed'(sh[15:0]);
        bx = 32'(b);
        hx = 32'(h);
        case (sz)
            2'b00:   load_fmt = sext ? bx : {24'd0, sh[7:0]};
            2'b01:   load_fmt = sext ? hx : {16'd0, sh[15:0]};
            default: load_fmt = d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            size_l        <= 2'b00;
            lane_l        <= 2'b00;
            sext_l        <= 1'b0;
            rdata         <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
            exc_align     <= 1'b0;
            exc_bus       <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= 4'b0000;
            mem.mem_wdata <= '0;
        end else begin
            done      <= 1'b0;
            exc_align <= 1'b0;
            exc_bus   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        size_l <= size;
                        lane_l <= addr[1:0];
                        sext_l <= sign_ext;
                        busy   <= 1'b1;
                        if (misaligned(size, addr[1:0])) begin
                            state     <= ERR;
                            done      <= 1'b1;
                            exc_align <= 1'b1;
                        end else begin
                            state         <= REQ;
                            cnt           <= '0;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= we;
                            mem.mem_addr  <= addr[ADDR_W-1:2];
                            mem.mem_be    <= lane_be(size, addr[1:0]);
                            mem.mem_wdata <= lane_wdata(size, wdata);
                        end
                    end
                end
                // Ack wins over a timeout landing on the same edge.
                REQ: begin
                    if (mem.mem_ack) begin
                        if (!mem.mem_we)
                            rdata <= load_fmt(size_l, lane_l, sext_l, mem.mem_rdata);
                        state <= RESP;
                        done  <= 1'b1;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state   <= ERR;
                        done    <= 1'b1;
                        exc_bus <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    if (mem.mem_ack || (cnt == CNT_W'(TIMEOUT - 1))) begin
                        mem.mem_req   <= 1'b0;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= '0;
                        mem.mem_be    <= 4'b0000;
                        mem.mem_wdata <= '0;
                    end
                end
                RESP, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Randomised and directed checks of dm_access_ctrl against a transaction-level
// model of lane steering, load extension, alignment and timeout rules.
module tb_dm_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        exc_align;
    logic        exc_bus;

    dm_access_ctrl_if #(.ADDR_W(32)) mem_bus ();

    dm_access_ctrl #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .busy      (busy),
        .exc_align (exc_align),
        .exc_bus   (exc_bus),
        .mem       (mem_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Expected outputs for the current cycle
    logic        exp_req, exp_busy, exp_done, exp_ea, exp_eb, exp_we;
    logic [29:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] model_rdata;

    // Observations of the last transaction
    int          lat, lat_done, nreq;
    logic [29:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wd;
    logic        cap_ea, cap_eb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input int unsigned lane);
        if (sz == 2'd0) return 4'(1 << lane);
        if (sz == 2'd1) return (lane >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w % 256) * 32'h01010101;
        if (sz == 2'd1) return (w % 65536) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input int unsigned lane,
                                           input logic sx, input logic [31:0] d);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (d >> (8 * lane)) % 256;
            if (sx && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (d >> (8 * lane)) % 65536;
            if (sx && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    task automatic set_idle();
        exp_req = 0; exp_busy = 0; exp_done = 0; exp_ea = 0; exp_eb = 0;
    endtask

    task automatic set_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
        exp_req = 1; exp_busy = 1; exp_done = 0; exp_ea = 0; exp_eb = 0;
        exp_we = w; exp_addr = a[31:2]; exp_be = m_be(sz, a % 4); exp_wd = m_wd(sz, wd);
    endtask

    task automatic set_done(input logic ea, input logic eb);
        exp_req = 0; exp_busy = 1; exp_done = 1; exp_ea = ea; exp_eb = eb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_obs();
        tick();
        lat++;
        if (done === 1'b1 && lat_done == 0) begin
            lat_done = lat; cap_ea = exc_align; cap_eb = exc_bus;
        end
        if (mem_bus.mem_req === 1'b1) begin
            nreq++;
            if (nreq == 1) begin
                cap_addr = mem_bus.mem_addr; cap_be = mem_bus.mem_be; cap_wd = mem_bus.mem_wdata;
            end
        end
    endtask

    // Garbage on core inputs while busy; the controller must ignore it.
    task automatic scramble();
        req = 1'($urandom); we = 1'($urandom); size = 2'($urandom);
        sign_ext = 1'($urandom); addr = $urandom; wdata = $urandom;
    endtask

    // Entered in an IDLE cycle; dly = REQ cycles without ack before the ack.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int dly);
        lat = 0; lat_done = 0; nreq = 0; cap_ea = 0; cap_eb = 0;
        cap_addr = '0; cap_be = '0; cap_wd = '0;
        req = 1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        mem_bus.mem_ack = 1'($urandom); mem_bus.mem_rdata = $urandom;
        tick_obs();
        if (is_mis(sz, a)) begin
            set_done(1, 0);
            scramble(); mem_bus.mem_ack = 1'($urandom);
            tick_obs();
        end else begin
            for (int k = 0; k < TIMEOUT; k++) begin
                set_req(w, sz, a, wd);
                scramble();
                if (k == dly) begin
                    mem_bus.mem_ack = 1; mem_bus.mem_rdata = rd;
                end else begin
                    mem_bus.mem_ack = 0; mem_bus.mem_rdata = $urandom;
                end
                tick_obs();
                if (k == dly) begin
                    if (!w) model_rdata = m_load(sz, a % 4, sx, rd);
                    set_done(0, 0);
                    break;
                end
                if (k == TIMEOUT - 1) set_done(0, 1);
            end
            scramble(); mem_bus.mem_ack = 1'($urandom); mem_bus.mem_rdata = $urandom;
            tick_obs();
        end
        set_idle();
        req = 0; mem_bus.mem_ack = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", 32'(mem_bus.mem_req), 32'(exp_req));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("exc_align", 32'(exc_align), 32'(exp_ea));
            chk("exc_bus", 32'(exc_bus), 32'(exp_eb));
            chk("rdata", rdata, model_rdata);
            if (exp_req) begin
                chk("mem_we", 32'(mem_bus.mem_we), 32'(exp_we));
                chk("mem_addr", 32'(mem_bus.mem_addr), 32'(exp_addr));
                chk("mem_be", 32'(mem_bus.mem_be), 32'(exp_be));
                chk("mem_wdata", mem_bus.mem_wdata, exp_wd);
            end
        end
    end

    initial begin
        rst = 0; req = 0; we = 0; size = 0; sign_ext = 0; addr = 0; wdata = 0;
        mem_bus.mem_ack = 0; mem_bus.mem_rdata = 0;
        set_idle(); model_rdata = 0; exp_we = 0; exp_addr = 0; exp_be = 0; exp_wd = 0;
        tick();
        chk_en = 1;
        tick();
        rst = 1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Word store, ack on first REQ cycle
        do_access(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        chk("sw_addr", 32'(cap_addr), 32'h40);
        chk("sw_be", 32'(cap_be), 32'hF);
        chk("sw_wdata", cap_wd, 32'hDEADBEEF);
        chk("sw_latency", 32'(lat_done), 32'd2);
        chk("sw_rdata", rdata, 32'h0);

        // Byte loads after 3 wait cycles
        do_access(0, 2'd0, 1, 32'h103, 32'h0, 32'h80112233, 3);
        chk("lb_be", 32'(cap_be), 32'h8);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        chk("lb_latency", 32'(lat_done), 32'd5);
        do_access(0, 2'd0, 0, 32'h103, 32'h0, 32'h80112233, 3);
        chk("lbu_rdata", rdata, 32'h00000080);

        // Halfword load and store
        do_access(0, 2'd1, 0, 32'h202, 32'h0, 32'hABCD1234, 1);
        chk("lhu_be", 32'(cap_be), 32'hC);
        chk("lhu_rdata", rdata, 32'h0000ABCD);
        do_access(1, 2'd1, 0, 32'h202, 32'h5678, 32'h0, 0);
        chk("sh_wdata", cap_wd, 32'h56785678);
        chk("sh_be", 32'(cap_be), 32'hC);
        chk("sh_rdata", rdata, 32'h0000ABCD);

        // Misaligned: lh 0x101, size 11, lw 0x102
        do_access(0, 2'd1, 0, 32'h101, 32'h0, 32'h0, 0);
        chk("lh_mis_nreq", 32'(nreq), 32'd0);
        chk("lh_mis_lat", 32'(lat_done), 32'd1);
        chk("lh_mis_exc", 32'(cap_ea), 32'd1);
        do_access(1, 2'd3, 0, 32'h100, 32'h0, 32'h0, 0);
        chk("sz3_nreq", 32'(nreq), 32'd0);
        chk("sz3_exc", 32'(cap_ea), 32'd1);
        do_access(0, 2'd2, 0, 32'h102, 32'h0, 32'h0, 0);
        chk("lw_mis_nreq", 32'(nreq), 32'd0);
        chk("lw_mis_lat", 32'(lat_done), 32'd1);
        chk("lw_mis_exc", 32'(cap_ea), 32'd1);

        // Timeout with no ack, then a late ack in IDLE
        do_access(0, 2'd2, 0, 32'h400, 32'h0, 32'h0, TIMEOUT);
        chk("to_nreq", 32'(nreq), 32'd16);
        chk("to_exc_bus", 32'(cap_eb), 32'd1);
        chk("to_lat", 32'(lat_done), 32'd17);
        mem_bus.mem_ack = 1; mem_bus.mem_rdata = 32'h11111111;
        tick();
        mem_bus.mem_ack = 0;
        chk("late_ack_rdata", rdata, 32'h0000ABCD);

        // Ack on the last REQ cycle completes normally
        do_access(0, 2'd2, 0, 32'h404, 32'h0, 32'h0F0F0F0F, TIMEOUT - 1);
        chk("ack16_nreq", 32'(nreq), 32'd16);
        chk("ack16_exc_bus", 32'(cap_eb), 32'd0);
        chk("ack16_lat", 32'(lat_done), 32'd17);
        chk("ack16_rdata", rdata, 32'h0F0F0F0F);

        // Reset during the second REQ cycle with a pending ack
        req = 1; we = 0; size = 2'd2; sign_ext = 0; addr = 32'h300; wdata = 0;
        tick();
        set_req(0, 2'd2, 32'h300, 32'h0);
        req = 0;
        tick();
        rst = 0; mem_bus.mem_ack = 1; mem_bus.mem_rdata = 32'hFFFFFFFF;
        tick();
        set_idle(); model_rdata = 0;
        rst = 1; mem_bus.mem_ack = 0;
        chk("rst_mid_rdata", rdata, 32'h0);
        chk("rst_mid_mem_req", 32'(mem_bus.mem_req), 32'h0);
        chk("rst_mid_done", 32'(done), 32'h0);
        do_access(0, 2'd2, 0, 32'h0, 32'h0, 32'h12345678, 1);
        chk("post_rst_lw", rdata, 32'h12345678);

        // Randomised accesses
        for (int i = 0; i < 300; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int          r, dly;
            sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            a  = $urandom;
            if ($urandom % 2 == 1) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            r = int'($urandom % 10);
            if (r < 7)       dly = int'($urandom % 4);
            else if (r == 7) dly = TIMEOUT - 1;
            else if (r == 8) dly = TIMEOUT;
            else             dly = int'($urandom % 8);
            do_access(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, dly);
            repeat ($urandom % 3) begin
                req = 0; mem_bus.mem_ack = 1'($urandom); mem_bus.mem_rdata = $urandom;
                tick();
            end
            mem_bus.mem_ack = 0;
        end

        tick();
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
